// File: rtl/bh_run_monitor_pkg.sv
// Shared brainhack definitions: datapath widths, END opcode, run-monitor defaults,
// FSM state encoding and counter slot indices.
package bh_run_monitor_pkg;

    localparam int BH_PRGMEM_ADDR_WIDTH = 8;
    localparam int BH_INSTR_WIDTH       = 4;
    localparam int BH_TAPE_ADDR_WIDTH   = 8;
    localparam int BH_STACK_WIDTH       = 8;
    localparam logic [BH_INSTR_WIDTH-1:0] BH_END_OPCODE = 4'hF;

    localparam int BH_CNT_WIDTH   = 32;
    localparam int BH_TIMEOUT     = 500;
    localparam int BH_TRACE_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } run_state_t;

    // Slot order of the event counter bank
    localparam int CNT_CYCLES = 0;
    localparam int CNT_INSTRS = 1;
    localparam int CNT_SKIPS  = 2;
    localparam int NUM_CNT    = 3;

endpackage

// File: rtl/bh_trace_buf.sv
// Circular register file of recent fetches; combinational readout where
// rd_idx 0 is the newest entry. count saturates at DEPTH.
module bh_trace_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 20,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wptr_reg;
    logic [AW:0]      count_reg;
    logic [AW-1:0]    rd_addr;

    always_ff @(posedge clk) begin
        if (wr_en) mem_reg[wptr_reg] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            wptr_reg  <= '0;
            count_reg <= '0;
        end else if (wr_en) begin
            wptr_reg <= wptr_reg + AW'(1);
            if (count_reg != (AW+1)'(DEPTH)) count_reg <= count_reg + (AW+1)'(1);
        end
    end

    // Pointer arithmetic wraps naturally modulo DEPTH (power of two)
    assign rd_addr = wptr_reg - rd_idx - AW'(1);
    assign rd_data = mem_reg[rd_addr];
    assign count   = count_reg;

endmodule

// File: rtl/bh_run_monitor.sv
// Run controller for the brainhack core: gates core_run, counts cycles, fetches and
// skip-loop episodes, stops on END or timeout. Fetch trace enabled by BH_TRACE_EN.
module bh_run_monitor
    import bh_run_monitor_pkg::*;
#(
    parameter int PRGMEM_ADDR_WIDTH = BH_PRGMEM_ADDR_WIDTH,
    parameter int INSTR_WIDTH       = BH_INSTR_WIDTH,
    parameter int TAPE_ADDR_WIDTH   = BH_TAPE_ADDR_WIDTH,
    parameter int CNT_WIDTH         = BH_CNT_WIDTH,
    parameter int TIMEOUT           = BH_TIMEOUT,
    parameter logic [INSTR_WIDTH-1:0] END_OPCODE = BH_END_OPCODE,
    parameter int TRACE_DEPTH       = BH_TRACE_DEPTH,
    localparam int IDX_WIDTH        = $clog2(TRACE_DEPTH),
    localparam int ENTRY_WIDTH      = PRGMEM_ADDR_WIDTH + INSTR_WIDTH + TAPE_ADDR_WIDTH
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_fetch,
    input  logic [INSTR_WIDTH-1:0]       i_ir,
    input  logic [PRGMEM_ADDR_WIDTH-1:0] i_pc,
    input  logic [TAPE_ADDR_WIDTH-1:0]   i_tape_addr,
    input  logic                         i_skip_loop,
    output logic                         o_core_run,
    output logic                         o_done,
    output logic                         o_timeout,
    output logic [CNT_WIDTH-1:0]         o_cycles,
    output logic [CNT_WIDTH-1:0]         o_instrs,
    output logic [CNT_WIDTH-1:0]         o_skips,
    input  logic [IDX_WIDTH-1:0]         i_trace_idx,
    output logic [ENTRY_WIDTH-1:0]       o_trace_entry,
    output logic [IDX_WIDTH:0]           o_trace_count
);

    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT - 1);

    run_state_t state_reg, state_next;
    logic in_run, start_run, end_hit, tmo_hit;
    logic skip_prev_reg, skip_rise;
    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_val;

    assign in_run    = (state_reg == ST_RUN);
    assign start_run = !in_run && i_start;
    assign skip_rise = i_skip_loop && !skip_prev_reg;
    assign cnt_inc   = {skip_rise, i_fetch, 1'b1};

    always_ff @(posedge i_clock) begin
        if (i_reset) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // END takes priority over a timeout landing on the same cycle
    always_comb begin
        state_next = state_reg;
        end_hit    = i_fetch && (i_ir == END_OPCODE);
        tmo_hit    = TMO_EN && (cnt_val[CNT_CYCLES] == TMO_LAST);
        case (state_reg)
            ST_RUN: begin
                if (end_hit)      state_next = ST_DONE;
                else if (tmo_hit) state_next = ST_TMO;
            end
            default: begin
                if (i_start) state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || start_run) skip_prev_reg <= 1'b0;
        else if (in_run)          skip_prev_reg <= i_skip_loop;
    end

    // Saturating event counters: hold at all-ones instead of wrapping
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        logic [CNT_WIDTH-1:0] count_reg;
        always_ff @(posedge i_clock) begin
            if (i_reset || start_run)
                count_reg <= '0;
            else if (in_run && cnt_inc[gi] && (count_reg != '1))
                count_reg <= count_reg + CNT_WIDTH'(1);
        end
        assign cnt_val[gi] = count_reg;
    end

    assign o_core_run = in_run;
    assign o_done     = (state_reg == ST_DONE);
    assign o_timeout  = (state_reg == ST_TMO);
    assign o_cycles   = cnt_val[CNT_CYCLES];
    assign o_instrs   = cnt_val[CNT_INSTRS];
    assign o_skips    = cnt_val[CNT_SKIPS];

`ifdef BH_TRACE_EN
    bh_trace_buf #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (ENTRY_WIDTH)
    ) u_trace (
        .clk     (i_clock),
        .srst    (i_reset),
        .clr     (start_run),
        .wr_en   (in_run && i_fetch),
        .wr_data ({i_pc, i_ir, i_tape_addr}),
        .rd_idx  (i_trace_idx),
        .rd_data (o_trace_entry),
        .count   (o_trace_count)
    );
`else
    logic unused_trace;
    assign unused_trace  = ^{i_trace_idx, i_pc, i_tape_addr};
    assign o_trace_entry = '0;
    assign o_trace_count = '0;
`endif

endmodule
